// File: rtl/pc_next_sequencer.sv
// PC register, next-PC selection and BOOT/RUN/HALT sequencing for the single-cycle core.
// Optional feature: define PC_ALIGN_CHECK_EN to trap misaligned next-PC values.
module pc_next_sequencer #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  CNT_WIDTH    = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Step,
  input  logic                 Branch,
  input  logic                 Zero,
  input  logic                 Jump,
  input  logic [PC_WIDTH-1:0]  Branch_Off_SL2,
  input  logic [25:0]          Jump_Index,
  input  logic                 Halt_Req,
  output logic [PC_WIDTH-1:0]  PC_OUT,
  output logic [PC_WIDTH-1:0]  PC_Plus4,
  output logic                 Fetch_Valid,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] Instr_Count,
  output logic                 Misalign_Fault
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] next_pc;
  logic                misalign;

  assign PC_Plus4 = PC_OUT + PC_WIDTH'(4);

  // Jump beats a taken branch; an untaken branch is an ordinary sequential step.
  always_comb begin
    next_pc = PC_Plus4;
    if (Jump)
      next_pc = {PC_Plus4[PC_WIDTH-1:28], Jump_Index, 2'b00};
    else if (Branch && Zero)
      next_pc = PC_Plus4 + Branch_Off_SL2;
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = |next_pc[1:0];

  always_ff @(posedge CLK) begin
    if (RST)
      Misalign_Fault <= 1'b0;
    else if (state == RUN && Step && misalign)
      Misalign_Fault <= 1'b1;
  end
`else
  assign misalign       = 1'b0;
  assign Misalign_Fault = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= BOOT;
      PC_OUT      <= RESET_VECTOR;
      Instr_Count <= '0;
      Fetch_Valid <= 1'b0;
      Halted      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          Fetch_Valid <= 1'b1;
        end
        RUN: begin
          // A faulting step is discarded and stops the core.
          if (Step && misalign) begin
            state       <= HALT;
            Fetch_Valid <= 1'b0;
            Halted      <= 1'b1;
          end else begin
            if (Step) begin
              PC_OUT      <= next_pc;
              Instr_Count <= Instr_Count + CNT_WIDTH'(1);
            end
            if (Halt_Req) begin
              state       <= HALT;
              Fetch_Valid <= 1'b0;
              Halted      <= 1'b1;
            end
          end
        end
        HALT: begin
          Fetch_Valid <= 1'b0;
          Halted      <= 1'b1;
        end
        default: begin
          state       <= BOOT;
          Fetch_Valid <= 1'b0;
          Halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule
